bios_rom_arbiter: RTL and testbench

- Shares one read port of the dual-port BIOS ROM between NUM_REQ requesters, e.g. debug loader, secondary fetch and DMA.
- Uses a valid/ready request handshake and round-robin arbitration.
- Tracks in-flight reads through the fixed ROM read latency and steers each returned word back to its originating requester.
- Sits between the requesters and the ROM's read2 port; read1 stays dedicated to the instruction fetch stage.

---
 rtl/bios_rom_arbiter_pkg.sv | 25 ++
 rtl/bios_rom_arbiter_if.sv | 33 +++
 rtl/bios_rom_arbiter_rr_arbiter.sv | 48 ++++
 rtl/bios_rom_arbiter.sv | 119 +++++++++++
 tb/tb_bios_rom_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bios_rom_arbiter_pkg.sv
// Shared types and constants for the BIOS ROM and its read2-port arbiter.
//   word_t                 32-bit bus word
//   BIOS_ROM_ADDR_BITS     byte-address width covered by the ROM (4 KiB)
//   BIOS_ROM_READ_LATENCY  ROM read latency in cycles
//   bios_arb_tag_t         in-flight read tag: valid, requester index, error
//   bios_addr_err()        out-of-range or misaligned byte address check
package bios_rom_arbiter_pkg;

  typedef logic [31:0] word_t;

  localparam int BIOS_ROM_ADDR_BITS    = 12;
  localparam int BIOS_ROM_READ_LATENCY = 1;

  // idx is sized for the largest legal requester count (8).
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic       err;
  } bios_arb_tag_t;

  function automatic logic bios_addr_err(word_t addr, int unsigned addr_bits);
    return ((addr >> addr_bits) != '0) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/bios_rom_arbiter_if.sv
// Requester-side bus of the BIOS ROM arbiter. Signal suffixes are from the
// arbiter's point of view.
//   req_valid_i   per-requester request valid
//   req_ready_o   per-requester grant (handshake = valid & ready)
//   req_addr_i    per-requester byte address
//   resp_valid_o  per-requester one-cycle response strobe
//   resp_data_o   shared response word, qualified by resp_valid_o
//   resp_err_o    shared response error flag, qualified by resp_valid_o
// Modports: master (requesters), slave (arbiter).
interface bios_rom_arbiter_if
  import bios_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0] req_valid_i;
  logic [NUM_REQ-1:0] req_ready_o;
  word_t              req_addr_i [NUM_REQ];
  logic [NUM_REQ-1:0] resp_valid_o;
  word_t              resp_data_o;
  logic               resp_err_o;

  modport master (
    output req_valid_i, req_addr_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_err_o
  );

endinterface

// File: rtl/bios_rom_arbiter_rr_arbiter.sv
// Generic N-wide round-robin grant generator with a last-grant pointer.
//   clk_i, reset_ni  clock, async active-low reset
//   req_i            request vector
//   advance_i        commit the current grant (moves the pointer)
//   gnt_o            one-hot grant, combinational
//   gnt_idx_o        index of the granted bit (valid when gnt_o != 0)
// After reset the pointer sits at N-1 so bit 0 has highest priority.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] last_q;
  logic          found;
  int            c;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    c         = 0;
    // Scan starts one past the last grant and wraps.
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_q) + k) % N;
      if (!found && req_i[c]) begin
        found     = 1'b1;
        gnt_o[c]  = 1'b1;
        gnt_idx_o = IW'(c);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_q <= IW'(N - 1);
    end else if (advance_i && found) begin
      last_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/bios_rom_arbiter.sv
// Shares the BIOS ROM read2 port between NUM_REQ requesters with a
// valid/ready handshake and round-robin arbitration, tracks reads through the
// fixed ROM latency and steers each returned word to its requester.
//   clk_i, reset_ni  clock, async active-low reset
//   bus              requester bus (bios_rom_arbiter_if.slave)
//   rom_addr_o       address to the ROM read port
//   rom_rdata_i      ROM read data, READ_LATENCY cycles after the address
// Optional: define BIOS_ROM_ARB_PRIORITY_EN to give requester 0 absolute
// priority; the others then share round-robin among themselves.
module bios_rom_arbiter
  import bios_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int READ_LATENCY  = BIOS_ROM_READ_LATENCY,
  parameter int ROM_ADDR_BITS = BIOS_ROM_ADDR_BITS
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  bios_rom_arbiter_if.slave    bus,
  output word_t                rom_addr_o,
  input  word_t                rom_rdata_i
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               hs;
  word_t              gnt_addr;
  logic               gnt_err;
  word_t              hold_q;
  bios_arb_tag_t      pipe_q [READ_LATENCY];
  bios_arb_tag_t      pipe_d [READ_LATENCY];
  bios_arb_tag_t      tail;

`ifdef BIOS_ROM_ARB_PRIORITY_EN
  localparam int RR_N  = NUM_REQ - 1;
  localparam int RR_IW = (RR_N > 1) ? $clog2(RR_N) : 1;

  logic [RR_N-1:0]  rr_gnt;
  logic [RR_IW-1:0] rr_idx;

  // Grants to requester 0 must not move the shared pointer.
  rr_arbiter #(.N(RR_N), .IW(RR_IW)) u_rr (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .req_i     (bus.req_valid_i[NUM_REQ-1:1]),
    .advance_i (hs & ~bus.req_valid_i[0]),
    .gnt_o     (rr_gnt),
    .gnt_idx_o (rr_idx)
  );

  always_comb begin
    if (bus.req_valid_i[0]) begin
      gnt     = NUM_REQ'(1);
      gnt_idx = '0;
    end else begin
      gnt     = {rr_gnt, 1'b0};
      gnt_idx = IW'(rr_idx) + IW'(1);
    end
  end
`else
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .req_i     (bus.req_valid_i),
    .advance_i (hs),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );
`endif

  // Ready is forced low while reset is asserted, even with valid requests.
  always_comb begin
    bus.req_ready_o = gnt & {NUM_REQ{reset_ni}};
    hs              = |bus.req_ready_o;
    gnt_addr        = bus.req_addr_i[gnt_idx];
    gnt_err         = bios_addr_err(gnt_addr, ROM_ADDR_BITS);
    rom_addr_o      = hs ? gnt_addr : hold_q;
  end

  always_comb begin
    pipe_d[0]       = '0;
    pipe_d[0].valid = hs;
    pipe_d[0].idx   = 3'(gnt_idx);
    pipe_d[0].err   = hs & gnt_err;
    for (int s = 1; s < READ_LATENCY; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        pipe_q[s] <= '0;
      end
      hold_q <= '0;
    end else begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        pipe_q[s] <= pipe_d[s];
      end
      if (hs) begin
        hold_q <= gnt_addr;
      end
    end
  end

  // The last stage lines up with the ROM data for that read.
  always_comb begin
    tail             = pipe_q[READ_LATENCY-1];
    bus.resp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.resp_valid_o[i] = tail.valid && (tail.idx == 3'(i));
    end
    bus.resp_err_o  = tail.valid & tail.err;
    bus.resp_data_o = (tail.valid && !tail.err) ? rom_rdata_i : '0;
  end

endmodule

// File: tb/tb_bios_rom_arbiter.sv
module tb_bios_rom_arbiter;
  import bios_rom_arbiter_pkg::*;

  localparam int N = 3;
  localparam int L = BIOS_ROM_READ_LATENCY;

  logic  clk = 1'b0;
  logic  reset_ni = 1'b0;
  word_t rom_addr;
  word_t rom_rdata;
  int    total = 0;
  int    bad = 0;
  int    pcnt [N];

  always #5 clk = ~clk;

  bios_rom_arbiter_if #(.NUM_REQ(N)) bus_if ();

  bios_rom_arbiter #(
    .NUM_REQ(N), .READ_LATENCY(L), .ROM_ADDR_BITS(BIOS_ROM_ADDR_BITS)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .bus(bus_if),
    .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata)
  );

  function automatic word_t rom_word(input logic [9:0] w);
    return 32'hB105_0000 | {22'd0, w};
  endfunction

  // ROM: word at rom_addr appears L cycles later.
  word_t rom_pipe [L];
  always @(posedge clk) begin
    for (int s = L - 1; s > 0; s--) rom_pipe[s] <= rom_pipe[s-1];
    rom_pipe[0] <= rom_word(rom_addr[11:2]);
  end
  assign rom_rdata = rom_pipe[L-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    int    due;
    int    idx;
    word_t data;
    logic  err;
  } rsp_t;
  rsp_t  mq[$];
  int    cyc = 0;
  int    last = N - 1;
  int    last_p = N - 1;
  word_t hold = '0;

  function automatic int pick();
    int best = -1;
    int bd = 1000;
    int d;
`ifdef BIOS_ROM_ARB_PRIORITY_EN
    if (bus_if.req_valid_i[0]) return 0;
    for (int i = 1; i < N; i++) begin
      d = (i - last_p - 1 + 2 * (N - 1)) % (N - 1);
      if (bus_if.req_valid_i[i] && d < bd) begin bd = d; best = i; end
    end
`else
    for (int i = 0; i < N; i++) begin
      d = (i - last - 1 + 2 * N) % N;
      if (bus_if.req_valid_i[i] && d < bd) begin bd = d; best = i; end
    end
`endif
    return best;
  endfunction

  initial begin
    int          g;
    word_t       ga;
    logic [31:0] e_rv;
    logic        e;
    forever begin
      @(negedge clk);
      g = -1;
      ga = '0;
      if (reset_ni) begin
        g = pick();
        if (g >= 0) ga = bus_if.req_addr_i[g];
        chk("m_ready", 32'(bus_if.req_ready_o), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("m_rom_addr", rom_addr, (g >= 0) ? ga : hold);
        e_rv = '0;
        if (mq.size() > 0 && mq[0].due == cyc) e_rv = 32'd1 << mq[0].idx;
        chk("m_resp_valid", 32'(bus_if.resp_valid_o), e_rv);
        if (e_rv != 0) begin
          chk("m_resp_data", bus_if.resp_data_o, mq[0].data);
          chk("m_resp_err", 32'(bus_if.resp_err_o), 32'(mq[0].err));
        end
      end else begin
        chk("m_rst_ready", 32'(bus_if.req_ready_o), 32'd0);
        chk("m_rst_resp_valid", 32'(bus_if.resp_valid_o), 32'd0);
      end
      @(posedge clk);
      if (!reset_ni) begin
        mq.delete();
        last = N - 1;
        last_p = N - 1;
        hold = '0;
      end else begin
        if (mq.size() > 0 && mq[0].due == cyc) void'(mq.pop_front());
        if (g >= 0) begin
          e = (ga >= 32'h1000) || (ga % 4 != 0);
          mq.push_back('{cyc + L, g, e ? 32'd0 : rom_word(ga[11:2]), e});
          hold = ga;
          last = g;
          if (g != 0) last_p = g;
        end
      end
      cyc++;
    end
  end

  initial begin
    for (int i = 0; i < N; i++) pcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (bus_if.resp_valid_o[i]) pcnt[i]++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [2:0] v, input word_t a0, input word_t a1, input word_t a2);
    @(posedge clk);
    #1;
    bus_if.req_valid_i = v;
    bus_if.req_addr_i[0] = a0;
    bus_if.req_addr_i[1] = a1;
    bus_if.req_addr_i[2] = a2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_ni = 1'b0;
    bus_if.req_valid_i = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;
  endtask

  typedef struct packed {
    logic [2:0] v;
    word_t      a0;
    word_t      a1;
    word_t      a2;
  } vec_t;

  localparam vec_t TV [10] = '{
    '{3'b111, 32'h100, 32'h204, 32'h3FC},
    '{3'b101, 32'hFFC, 32'h000, 32'h1001},
    '{3'b011, 32'h002, 32'h008, 32'h000},
    '{3'b000, 32'h000, 32'h000, 32'h000},
    '{3'b100, 32'h000, 32'h000, 32'hFFFF_0000},
    '{3'b111, 32'h010, 32'h014, 32'h018},
    '{3'b110, 32'h000, 32'h01C, 32'h020},
    '{3'b001, 32'h024, 32'h000, 32'h000},
    '{3'b010, 32'h000, 32'h028, 32'h000},
    '{3'b111, 32'h02C, 32'h030, 32'h034}
  };

  initial begin
    bus_if.req_valid_i = '0;
    for (int i = 0; i < N; i++) bus_if.req_addr_i[i] = '0;

    do_reset();
    @(negedge clk);
    chk("rst_ready", 32'(bus_if.req_ready_o), 32'd0);
    chk("rst_resp_valid", 32'(bus_if.resp_valid_o), 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    chk("rst_resp_err", 32'(bus_if.resp_err_o), 32'd0);

    // Lone requester 1
    drive(3'b010, 32'h0, 32'h10, 32'h0);
    @(negedge clk);
    chk("t1_ready", 32'(bus_if.req_ready_o), 32'b010);
    chk("t1_rom_addr", rom_addr, 32'h10);
    drive(3'b000, 32'h0, 32'h10, 32'h0);
    @(negedge clk);
    chk("t1_resp_valid", 32'(bus_if.resp_valid_o), 32'b010);
    chk("t1_resp_data", bus_if.resp_data_o, 32'hB105_0004);
    chk("t1_resp_err", 32'(bus_if.resp_err_o), 32'd0);
    chk("t1_idle_ready", 32'(bus_if.req_ready_o), 32'd0);
    chk("t1_addr_hold", rom_addr, 32'h10);

`ifndef BIOS_ROM_ARB_PRIORITY_EN
    // Three-way contention
    begin
      logic [2:0] ord [6];
      ord = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      do_reset();
      for (int i = 0; i < N; i++) pcnt[i] = 0;
      for (int k = 0; k < 6; k++) begin
        drive(3'b111, 32'h0, 32'h4, 32'h8);
        @(negedge clk);
        chk("t2_grant", 32'(bus_if.req_ready_o), 32'(ord[k]));
      end
      drive(3'b000, 32'h0, 32'h0, 32'h0);
      drive(3'b000, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      for (int i = 0; i < N; i++) chk("t2_pulses", 32'(pcnt[i]), 32'd2);
    end
`endif

    // Erroring addresses from requester 2
    do_reset();
    drive(3'b100, 32'h0, 32'h0, 32'h1000);
    @(negedge clk);
    chk("t3_ready_a", 32'(bus_if.req_ready_o), 32'b100);
    drive(3'b100, 32'h0, 32'h0, 32'h6);
    @(negedge clk);
    chk("t3_ready_b", 32'(bus_if.req_ready_o), 32'b100);
    chk("t3_rv_a", 32'(bus_if.resp_valid_o), 32'b100);
    chk("t3_err_a", 32'(bus_if.resp_err_o), 32'd1);
    chk("t3_data_a", bus_if.resp_data_o, 32'd0);
    drive(3'b000, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t3_rv_b", 32'(bus_if.resp_valid_o), 32'b100);
    chk("t3_err_b", 32'(bus_if.resp_err_o), 32'd1);
    chk("t3_data_b", bus_if.resp_data_o, 32'd0);

    // Reset pulse mid-cycle with a read in flight
    do_reset();
    drive(3'b001, 32'h20, 32'h0, 32'h0);
    @(negedge clk);
    chk("t4_ready", 32'(bus_if.req_ready_o), 32'b001);
    drive(3'b001, 32'h24, 32'h0, 32'h0);
    @(negedge clk);
    chk("t4_rv_before", 32'(bus_if.resp_valid_o), 32'b001);
    chk("t4_data_before", bus_if.resp_data_o, 32'hB105_0008);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("t4_rst_ready", 32'(bus_if.req_ready_o), 32'd0);
    chk("t4_rst_rv", 32'(bus_if.resp_valid_o), 32'd0);
    chk("t4_rst_addr", rom_addr, 32'd0);
    chk("t4_rst_err", 32'(bus_if.resp_err_o), 32'd0);
    @(posedge clk);
    #2;
    bus_if.req_valid_i = 3'b111;
    bus_if.req_addr_i[0] = 32'h0;
    bus_if.req_addr_i[1] = 32'h4;
    bus_if.req_addr_i[2] = 32'h8;
    reset_ni = 1'b1;
    @(negedge clk);
    chk("t4_no_resp", 32'(bus_if.resp_valid_o), 32'd0);
    chk("t4_ready_after", 32'(bus_if.req_ready_o), 32'b001);

    // Requesters 0 and 1 contending, then 0 drops
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(3'b011, 32'h30, 32'h40, 32'h0);
      @(negedge clk);
`ifdef BIOS_ROM_ARB_PRIORITY_EN
      chk("t5_prio_ready", 32'(bus_if.req_ready_o), 32'b001);
`else
      chk("t5_rr_ready", 32'(bus_if.req_ready_o), (k % 2 == 0) ? 32'b001 : 32'b010);
`endif
    end
    drive(3'b010, 32'h30, 32'h40, 32'h0);
    @(negedge clk);
    chk("t5_drop_ready", 32'(bus_if.req_ready_o), 32'b010);

    // Back-to-back single requester, words 0..7
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      drive((i < 8) ? 3'b001 : 3'b000, 32'(4 * i), 32'h0, 32'h0);
      @(negedge clk);
      if (i < 8) chk("t6_ready", 32'(bus_if.req_ready_o), 32'b001);
      if (i > 0) begin
        chk("t6_rv", 32'(bus_if.resp_valid_o), 32'b001);
        chk("t6_data", bus_if.resp_data_o, 32'hB105_0000 + 32'(i - 1));
      end
    end

    // Mixed directed vectors, checked by the model
    do_reset();
    for (int k = 0; k < 10; k++) drive(TV[k].v, TV[k].a0, TV[k].a1, TV[k].a2);
    drive(3'b000, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
